// File: rtl/gvt_tracker_if.sv
// GVT tracker bus: raw GVT and freeze in, committed GVT and status out.
interface gvt_tracker_if #(
  parameter int unsigned TS_WIDTH = 16,
  parameter int unsigned TB_WIDTH = 16,
  parameter int unsigned CNT_W    = 32
);
  localparam int unsigned VT_W = TS_WIDTH + TB_WIDTH;

  logic [VT_W-1:0]  gvt_in;
  logic             freeze;
  logic [VT_W-1:0]  gvt;
  logic             gvt_valid;
  logic             done;
  logic             err;
  logic [VT_W-1:0]  err_vt;
  logic [CNT_W-1:0] commits;

  // Source side: drives the raw GVT and freeze, observes committed state.
  modport master (
    output gvt_in, freeze,
    input  gvt, gvt_valid, done, err, err_vt, commits
  );

  // Tracker side.
  modport slave (
    input  gvt_in, freeze,
    output gvt, gvt_valid, done, err, err_vt, commits
  );
endinterface

// File: rtl/gvt_tracker.sv
// Turns the raw min-tree GVT into a monotonic committed GVT: blanks the tree
// fill latency, debounces the candidate, flags regressions, detects termination.
module gvt_tracker #(
  parameter int unsigned TS_WIDTH      = 16,
  parameter int unsigned TB_WIDTH      = 16,
  parameter int unsigned N_TILES       = 16,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 32
) (
  input logic         clk,
  input logic         rst,
  gvt_tracker_if.slave bus
);
  localparam int unsigned VT_W        = TS_WIDTH + TB_WIDTH;
  localparam int unsigned FILL_CYCLES = $clog2(N_TILES) + 3;
  localparam int unsigned FC_W        = $clog2(FILL_CYCLES + 1);
  localparam int unsigned SC_W        = $clog2(STABLE_CYCLES + 1);

  typedef enum logic {FILL, TRACK} state_t;

  state_t           state, state_d;
  logic [FC_W-1:0]  fill_cnt, fill_cnt_d;
  logic [SC_W-1:0]  stable_cnt, stable_cnt_d;
  logic [VT_W-1:0]  cand, cand_d;
  logic [VT_W-1:0]  gvt_q, gvt_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [VT_W-1:0]  err_vt_q, err_vt_d;
  logic [CNT_W-1:0] commits_q, commits_d;

  // State and datapath registers; reset restarts the fill blanking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      fill_cnt   <= '0;
      stable_cnt <= '0;
      cand       <= '0;
      gvt_q      <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_vt_q   <= '0;
      commits_q  <= '0;
    end else begin
      state      <= state_d;
      fill_cnt   <= fill_cnt_d;
      stable_cnt <= stable_cnt_d;
      cand       <= cand_d;
      gvt_q      <= gvt_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_vt_q   <= err_vt_d;
      commits_q  <= commits_d;
    end
  end

  // Next-state: fill countdown, then debounce candidate and commit/flag.
  always_comb begin
    state_d      = state;
    fill_cnt_d   = fill_cnt;
    stable_cnt_d = stable_cnt;
    cand_d       = cand;
    gvt_d        = gvt_q;
    valid_d      = 1'b0;
    done_d       = done_q;
    err_d        = err_q;
    err_vt_d     = err_vt_q;
    commits_d    = commits_q;

    unique case (state)
      FILL: begin
        fill_cnt_d = fill_cnt + FC_W'(1);
        if (fill_cnt == FC_W'(FILL_CYCLES - 1)) begin
          state_d      = TRACK;
          cand_d       = bus.gvt_in;
          stable_cnt_d = SC_W'(1);
        end
      end
      TRACK: begin
        if (bus.freeze) begin
          stable_cnt_d = '0;
        end else if (bus.gvt_in != cand) begin
          cand_d       = bus.gvt_in;
          stable_cnt_d = SC_W'(1);
        end else if (stable_cnt < SC_W'(STABLE_CYCLES - 1)) begin
          stable_cnt_d = stable_cnt + SC_W'(1);
        end else if (stable_cnt == SC_W'(STABLE_CYCLES - 1)) begin
          // Candidate just became stable: evaluate once, then saturate.
          stable_cnt_d = SC_W'(STABLE_CYCLES);
          if (cand > gvt_q) begin
            gvt_d     = cand;
            valid_d   = 1'b1;
            commits_d = commits_q + CNT_W'(1);
            if (&cand[VT_W-1 -: TS_WIDTH]) done_d = 1'b1;
          end else if (cand < gvt_q) begin
            err_d = 1'b1;
            if (!err_q) err_vt_d = cand;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  assign bus.gvt       = gvt_q;
  assign bus.gvt_valid = valid_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_vt    = err_vt_q;
  assign bus.commits   = commits_q;
endmodule

// File: tb/tb_gvt_tracker.sv
// Directed bench for gvt_tracker: fill blanking, debounce latency, regression,
// freeze, termination and mid-count reset.
module tb_gvt_tracker;
  localparam int unsigned TS_WIDTH = 16;
  localparam int unsigned TB_WIDTH = 16;
  localparam int unsigned CNT_W    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  gvt_tracker_if #(.TS_WIDTH(TS_WIDTH), .TB_WIDTH(TB_WIDTH), .CNT_W(CNT_W)) bus_if ();

  gvt_tracker #(
    .TS_WIDTH(TS_WIDTH), .TB_WIDTH(TB_WIDTH), .N_TILES(16),
    .STABLE_CYCLES(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare observed against expected and record the result.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus_if.gvt_in = 32'h10;
    bus_if.freeze = 1'b0;
    step(2);
    chk("rst_gvt", 64'(bus_if.gvt), 64'h0);
    chk("rst_valid", 64'(bus_if.gvt_valid), 64'h0);
    chk("rst_commits", 64'(bus_if.commits), 64'd0);
    chk("rst_err", 64'(bus_if.err), 64'h0);

    // 1: first commit exactly FILL(7)+STABLE(4)-1 = 10 edges after release.
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step(1);
      chk("fill_no_valid", 64'(bus_if.gvt_valid), 64'h0);
      chk("fill_gvt", 64'(bus_if.gvt), 64'h0);
    end
    step(1);
    chk("t1_gvt", 64'(bus_if.gvt), 64'h10);
    chk("t1_valid", 64'(bus_if.gvt_valid), 64'h1);
    chk("t1_commits", 64'(bus_if.commits), 64'd1);
    step(1);
    chk("t1_pulse_end", 64'(bus_if.gvt_valid), 64'h0);

    // 2: short-lived 0x20 is dropped; 0x30 commits 4 edges after it appears.
    bus_if.gvt_in = 32'h20;
    step(2);
    bus_if.gvt_in = 32'h30;
    step(3);
    chk("t2_gvt_before", 64'(bus_if.gvt), 64'h10);
    chk("t2_valid_before", 64'(bus_if.gvt_valid), 64'h0);
    step(1);
    chk("t2_gvt", 64'(bus_if.gvt), 64'h30);
    chk("t2_valid", 64'(bus_if.gvt_valid), 64'h1);
    chk("t2_commits", 64'(bus_if.commits), 64'd2);

    // 3: regression flags err, first offender latched.
    bus_if.gvt_in = 32'h28;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("t3_no_valid", 64'(bus_if.gvt_valid), 64'h0);
    end
    chk("t3_err", 64'(bus_if.err), 64'h1);
    chk("t3_err_vt", 64'(bus_if.err_vt), 64'h28);
    chk("t3_gvt", 64'(bus_if.gvt), 64'h30);
    bus_if.gvt_in = 32'h18;
    step(6);
    chk("t3_err_vt_frozen", 64'(bus_if.err_vt), 64'h28);
    chk("t3_commits", 64'(bus_if.commits), 64'd2);

    // 4: freeze inhibits commit; release commits 4 edges later.
    bus_if.freeze = 1'b1;
    bus_if.gvt_in = 32'h40;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("t4_frozen_valid", 64'(bus_if.gvt_valid), 64'h0);
    end
    chk("t4_frozen_gvt", 64'(bus_if.gvt), 64'h30);
    bus_if.freeze = 1'b0;
    step(3);
    chk("t4_gvt_before", 64'(bus_if.gvt), 64'h30);
    step(1);
    chk("t4_gvt", 64'(bus_if.gvt), 64'h40);
    chk("t4_valid", 64'(bus_if.gvt_valid), 64'h1);
    chk("t4_commits", 64'(bus_if.commits), 64'd3);

    // 4b: freeze with unchanged candidate restarts the count from 0.
    bus_if.gvt_in = 32'h48;
    step(2);
    bus_if.freeze = 1'b1;
    step(3);
    bus_if.freeze = 1'b0;
    step(3);
    chk("t4b_gvt_before", 64'(bus_if.gvt), 64'h40);
    chk("t4b_valid_before", 64'(bus_if.gvt_valid), 64'h0);
    step(1);
    chk("t4b_gvt", 64'(bus_if.gvt), 64'h48);
    chk("t4b_commits", 64'(bus_if.commits), 64'd4);

    // 5: ts all ones -> done with the commit pulse, then sticky.
    bus_if.gvt_in = 32'hFFFF_0000;
    step(3);
    chk("t5_done_before", 64'(bus_if.done), 64'h0);
    step(1);
    chk("t5_gvt", 64'(bus_if.gvt), 64'hFFFF_0000);
    chk("t5_valid", 64'(bus_if.gvt_valid), 64'h1);
    chk("t5_done", 64'(bus_if.done), 64'h1);
    bus_if.gvt_in = 32'hFFFF_0001;
    step(4);
    chk("t5_tb_commit", 64'(bus_if.gvt), 64'hFFFF_0001);
    chk("t5_commits", 64'(bus_if.commits), 64'd6);
    step(3);
    chk("t5_done_sticky", 64'(bus_if.done), 64'h1);

    // 6: reset at stable_cnt==3 wipes everything; fill restarts.
    bus_if.gvt_in = 32'h50;
    step(3);
    rst = 1'b1;
    step(1);
    chk("t6_gvt", 64'(bus_if.gvt), 64'h0);
    chk("t6_valid", 64'(bus_if.gvt_valid), 64'h0);
    chk("t6_done", 64'(bus_if.done), 64'h0);
    chk("t6_err", 64'(bus_if.err), 64'h0);
    chk("t6_err_vt", 64'(bus_if.err_vt), 64'h0);
    chk("t6_commits", 64'(bus_if.commits), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step(1);
      chk("t6_refill_no_valid", 64'(bus_if.gvt_valid), 64'h0);
    end
    step(1);
    chk("t6_gvt_after", 64'(bus_if.gvt), 64'h50);
    chk("t6_valid_after", 64'(bus_if.gvt_valid), 64'h1);
    chk("t6_commits_after", 64'(bus_if.commits), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
